nor_input_conditioner: RTL and testbench

- Two-channel input conditioner that sits directly upstream of the 2-input NOR gate stage.
- Takes raw asynchronous inputs (switches or buttons) for operands a and b.
- Synchronises each into the clock domain and debounces it.
- Drives clean, glitch-free a_clean/b_clean into the NOR gate's a/b inputs, plus one-cycle edge pulses per channel for downstream event logic.

---
 rtl/nor_input_conditioner.sv | 150 +++++++++++++++
 tb/tb_nor_input_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_input_conditioner.sv
// Two-channel synchroniser + debouncer feeding the a/b inputs of a NOR stage.
// Each channel emits a glitch-free level and one-cycle rise/fall pulses.
module nor_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               NO_WAIT  = (DEBOUNCE_CYCLES == 1);

  // Index 0 is channel a, index 1 is channel b; state_q is the per-channel FSM state.
  logic                   raw     [2];
  logic                   s_sync  [2];
  logic [SYNC_STAGES-1:0] sync_q  [2];
  logic [SYNC_STAGES-1:0] sync_d  [2];
  state_e                 state_q [2];
  state_e                 state_d [2];
  logic [CNT_W-1:0]       cnt_q   [2];
  logic [CNT_W-1:0]       cnt_d   [2];
  logic                   clean_q [2];
  logic                   clean_d [2];
  logic                   rise_q  [2];
  logic                   rise_d  [2];
  logic                   fall_q  [2];
  logic                   fall_d  [2];

  assign raw[0]    = a_raw;
  assign raw[1]    = b_raw;
  assign s_sync[0] = sync_q[0][SYNC_STAGES-1];
  assign s_sync[1] = sync_q[1][SYNC_STAGES-1];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sync_d[c]  = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      clean_d[c] = clean_q[c];
      rise_d[c]  = 1'b0;
      fall_d[c]  = 1'b0;
      case (state_q[c])
        STABLE_LO: begin
          if (s_sync[c]) begin
            if (NO_WAIT) begin
              state_d[c] = STABLE_HI;
              clean_d[c] = 1'b1;
              rise_d[c]  = 1'b1;
              cnt_d[c]   = '0;
            end else begin
              state_d[c] = WAIT_HI;
              cnt_d[c]   = CNT_ONE;
            end
          end
        end
        WAIT_HI: begin
          if (!s_sync[c]) begin
            state_d[c] = STABLE_LO;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = STABLE_HI;
            clean_d[c] = 1'b1;
            rise_d[c]  = 1'b1;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s_sync[c]) begin
            if (NO_WAIT) begin
              state_d[c] = STABLE_LO;
              clean_d[c] = 1'b0;
              fall_d[c]  = 1'b1;
              cnt_d[c]   = '0;
            end else begin
              state_d[c] = WAIT_LO;
              cnt_d[c]   = CNT_ONE;
            end
          end
        end
        WAIT_LO: begin
          if (s_sync[c]) begin
            state_d[c] = STABLE_HI;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = STABLE_LO;
            clean_d[c] = 1'b0;
            fall_d[c]  = 1'b1;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        end
        default: begin
          state_d[c] = STABLE_LO;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= '0;
        state_q[c] <= STABLE_LO;
        cnt_q[c]   <= '0;
        clean_q[c] <= 1'b0;
        rise_q[c]  <= 1'b0;
        fall_q[c]  <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c]  <= sync_d[c];
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        clean_q[c] <= clean_d[c];
        rise_q[c]  <= rise_d[c];
        fall_q[c]  <= fall_d[c];
      end
    end
  end

  assign a_clean = clean_q[0];
  assign b_clean = clean_q[1];
  assign a_rise  = rise_q[0];
  assign a_fall  = fall_q[0];
  assign b_rise  = rise_q[1];
  assign b_fall  = fall_q[1];

endmodule

// File: tb/tb_nor_input_conditioner.sv
// Bench for nor_input_conditioner: three parameterisations side by side, each
// compared every edge against a run-length debounce model, plus directed corners.
module tb_nor_input_conditioner;

  localparam int S_P [3] = '{2, 3, 2};
  localparam int D_P [3] = '{4, 1, 16};

  logic clk;
  logic rst_n;
  logic a_raw_v   [3];
  logic b_raw_v   [3];
  logic a_clean_w [3];
  logic b_clean_w [3];
  logic a_rise_w  [3];
  logic a_fall_w  [3];
  logic b_rise_w  [3];
  logic b_fall_w  [3];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: s is the raw value sampled S edges earlier; clean flips once s has
  // disagreed with it for D consecutive edges.
  logic [3:0] m_hist  [3][2];
  logic       m_clean [3][2];
  logic       m_rise  [3][2];
  logic       m_fall  [3][2];
  int         m_run   [3][2];

  typedef struct {
    logic       a;
    logic       b;
    int         edges;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [8];

  nor_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw_v[0]), .b_raw(b_raw_v[0]),
    .a_clean(a_clean_w[0]), .b_clean(b_clean_w[0]),
    .a_rise(a_rise_w[0]), .a_fall(a_fall_w[0]),
    .b_rise(b_rise_w[0]), .b_fall(b_fall_w[0])
  );

  nor_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw_v[1]), .b_raw(b_raw_v[1]),
    .a_clean(a_clean_w[1]), .b_clean(b_clean_w[1]),
    .a_rise(a_rise_w[1]), .a_fall(a_fall_w[1]),
    .b_rise(b_rise_w[1]), .b_fall(b_fall_w[1])
  );

  nor_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw_v[2]), .b_raw(b_raw_v[2]),
    .a_clean(a_clean_w[2]), .b_clean(b_clean_w[2]),
    .a_rise(a_rise_w[2]), .a_fall(a_fall_w[2]),
    .b_rise(b_rise_w[2]), .b_fall(b_fall_w[2])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Vector layout: {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall}
  function automatic logic [5:0] dut_vec(input int i);
    return {a_clean_w[i], b_clean_w[i], a_rise_w[i], a_fall_w[i], b_rise_w[i], b_fall_w[i]};
  endfunction

  function automatic logic [5:0] model_vec(input int i);
    return {m_clean[i][0], m_clean[i][1], m_rise[i][0], m_fall[i][0], m_rise[i][1], m_fall[i][1]};
  endfunction

  task automatic check(input string name, input int inst, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %b expected %b (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input int inst, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %b expected %b (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_hist[i][c]  = '0;
        m_clean[i][c] = 1'b0;
        m_rise[i][c]  = 1'b0;
        m_fall[i][c]  = 1'b0;
        m_run[i][c]   = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic r;
    logic s;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        r = (c == 0) ? a_raw_v[i] : b_raw_v[i];
        s = m_hist[i][c][S_P[i]-1];
        m_hist[i][c] = {m_hist[i][c][2:0], r};
        m_rise[i][c] = 1'b0;
        m_fall[i][c] = 1'b0;
        if (s != m_clean[i][c]) m_run[i][c]++;
        else                    m_run[i][c] = 0;
        if (m_run[i][c] == D_P[i]) begin
          m_clean[i][c] = s;
          if (s) m_rise[i][c] = 1'b1;
          else   m_fall[i][c] = 1'b1;
          m_run[i][c] = 0;
        end
      end
    end
  endtask

  // One clock edge: advance the model, then compare every instance 1ns later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("model", i, dut_vec(i), model_vec(i));
      chk_bit("nor_y", i, ~(a_clean_w[i] | b_clean_w[i]), ~(m_clean[i][0] | m_clean[i][1]));
      chk_bit("a_excl", i, a_rise_w[i] & a_fall_w[i], 1'b0);
      chk_bit("b_excl", i, b_rise_w[i] & b_fall_w[i], 1'b0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0] = '{a: 1'b1, b: 1'b0, edges: 5, exp: 6'b000000};
    tbl[1] = '{a: 1'b1, b: 1'b0, edges: 1, exp: 6'b101000};
    tbl[2] = '{a: 1'b1, b: 1'b0, edges: 1, exp: 6'b100000};
    tbl[3] = '{a: 1'b1, b: 1'b1, edges: 3, exp: 6'b100000};
    tbl[4] = '{a: 1'b1, b: 1'b0, edges: 6, exp: 6'b100000};
    tbl[5] = '{a: 1'b0, b: 1'b1, edges: 6, exp: 6'b010110};
    tbl[6] = '{a: 1'b0, b: 1'b1, edges: 1, exp: 6'b010000};
    tbl[7] = '{a: 1'b1, b: 1'b0, edges: 6, exp: 6'b101001};

    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_raw_v[i] = 1'b1;
      b_raw_v[i] = 1'b1;
    end

    // Reset held with raw inputs high: everything stays cleared.
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 3; i++) check("reset_hold", i, dut_vec(i), 6'b000000);

    // Release with a already high on inst1/inst2: latency S+D after release.
    rst_n = 1'b1;
    a_raw_v[0] = 1'b0;
    b_raw_v[0] = 1'b0;
    b_raw_v[1] = 1'b0;
    b_raw_v[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3)  chk_bit("lat4_early", 1, a_clean_w[1], 1'b0);
      if (k == 4)  check("lat4_rise", 1, dut_vec(1), 6'b101000);
      if (k == 17) chk_bit("lat18_early", 2, a_clean_w[2], 1'b0);
      if (k == 18) check("lat18_rise", 2, dut_vec(2), 6'b101000);
    end

    // Table on inst0: step, glitch rejection, simultaneous edges.
    a_raw_v[1] = 1'b0;
    a_raw_v[2] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      a_raw_v[0] = tbl[t].a;
      b_raw_v[0] = tbl[t].b;
      for (int k = 0; k < tbl[t].edges; k++) step();
      check($sformatf("table%0d", t), 0, dut_vec(0), tbl[t].exp);
    end

    // b toggling every cycle never changes b_clean.
    for (int k = 0; k < 20; k++) begin
      b_raw_v[0] = ~b_raw_v[0];
      step();
      chk_bit("toggle_clean", 0, b_clean_w[0], 1'b0);
      chk_bit("toggle_rise", 0, b_rise_w[0], 1'b0);
    end
    b_raw_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // 15-cycle chatter on the 16-cycle instance is rejected, then a real step.
    a_raw_v[2] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk_bit("chatter15", 2, a_clean_w[2], 1'b0);
    end
    a_raw_v[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_bit("chatter15_after", 2, a_clean_w[2] | a_rise_w[2], 1'b0);
    end
    a_raw_v[2] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 17) chk_bit("d16_early", 2, a_clean_w[2], 1'b0);
      if (k == 18) check("d16_rise", 2, dut_vec(2), 6'b101000);
    end

    // Reset asserted mid-WAIT_HI on inst0 a, between edges.
    a_raw_v[0] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    a_raw_v[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("async_rst", i, dut_vec(i), 6'b000000);
    model_reset();
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 6) chk_bit("rst_mid_early", 0, a_clean_w[0] | a_rise_w[0], 1'b0);
      else       chk_bit("rst_mid_rise", 0, a_clean_w[0] & a_rise_w[0], 1'b1);
    end

    // Randomised holds and bursts on every channel of every instance.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3 * D_P[i]) == 0) a_raw_v[i] = ~a_raw_v[i];
        if ($urandom_range(0, 3 * D_P[i]) == 0) b_raw_v[i] = ~b_raw_v[i];
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
